scarv_cop_mem_resp: RTL and testbench
=====================================

# scarv_cop_mem_resp

Memory responder for the COP load/store bus (`cop_mem_*`). It is the far end of the coprocessor memory port and is used as the memory behind the load/store unit in integration benches and FPGA builds. It serves single-word, byte-enabled reads and writes from an internal word array and inserts programmable or pseudo-random wait states through `cop_mem_stall`. It reports out-of-range accesses through `cop_mem_error`.

## Interface
- `DEPTH_WORDS`, default 1024: array depth in 32-bit words; must be a power of two.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be word aligned.
- `g_clk` in 1: global clock; the only clock.
- `g_resetn` in 1: synchronous, active-low reset.
- `cop_mem_cen` in 1: request valid.
- `cop_mem_wen` in 1: 1 = write, 0 = read.
- `cop_mem_addr` in 32: byte address; bits [1:0] ignored.
- `cop_mem_wdata` in 32: write data, byte-lane positioned.
- `cop_mem_ben` in 4: write byte enables; ignored on reads.
- `cop_mem_rdata` out 32: read data; valid only in the completion cycle.
- `cop_mem_stall` out 1: outstanding request not yet complete.
- `cop_mem_error` out 1: bus error; valid only in the completion cycle.
- `cfg_wait` in 4: fixed wait states per request.
- `cfg_rand_en` in 1: adds 0–3 pseudo-random wait states per request.
- `stat_rd`, `stat_wr`, `stat_err` out 16 each: saturating completion counters.

## Operation
**State**
- One outstanding request at a time. Registers: `pend`, `cnt[4:0]`, `cap_wen`, `cap_idx`, `cap_oob`, `cap_wdata`, `cap_ben`, `lfsr[15:0]`.
- Completion cycle: `pend && cnt==0`.

**Accept**
- A request is accepted when `cop_mem_cen && (!pend || completion cycle)`.
- While `pend && cnt!=0`, `cop_mem_cen` is ignored. The initiator holds the same request during a stall, and it is not re-accepted.
- On accept, capture the request fields and set `pend` to 1.
- Load `cnt = cfg_wait + (cfg_rand_en ? lfsr[1:0] : 0)`, computed 5 bits wide with no overflow.
- Advance `lfsr` on accept only.

**Wait**
- When `pend && cnt!=0`: `cnt` decrements by 1 per cycle and `cop_mem_stall` = 1.

**Address decode**
- `off = cop_mem_addr - BASE_ADDR` (32-bit, wrapping).
- `cap_oob = off[31:2] >= DEPTH_WORDS`, unsigned.
- `cap_idx = off[log2(DEPTH_WORDS)+1:2]`.

**Completion cycle**
- `cop_mem_stall` = 0.
- `cop_mem_error = cap_oob`.
- `cop_mem_rdata` = `mem[cap_idx]` (combinational) for an in-range read; 0 otherwise, including writes and errors.
- At the closing edge, an in-range write updates byte i of `mem[cap_idx]` for each set `cap_ben[i]`. Out-of-range writes are dropped.
- At the closing edge, `pend` clears unless a new request is accepted in the same cycle.

**Back-to-back requests**
- A request accepted in a completion cycle starts its own response; no idle cycle is required.
- A read immediately after a write to the same word returns the written data, because the write commits before the read's completion cycle.

**Statistics counters**
- Each increments by 1 per completion and saturates at 16'hFFFF.
- In-range read → `stat_rd`; in-range write → `stat_wr`; out-of-range → `stat_err` only.

**LFSR**
- Galois, polynomial x^16+x^14+x^13+x^11+1.
- Reset seed 16'hACE1.

## Timing
- Request accepted in cycle A with total waits k → `cop_mem_stall` is 1 in cycles A+1..A+k, and cycle A+k+1 is the completion cycle. Zero-wait latency is 1 cycle.
- `cop_mem_stall`, `cop_mem_error`, `cop_mem_rdata` are decoded from registered state only, with no combinational path from `cop_mem_cen`. `cop_mem_rdata` also depends on array contents.
- Outside completion cycles: `cop_mem_error` = 0 and `cop_mem_rdata` = 0.
- Reset values:
  - `pend` = 0, `cnt` = 0, `lfsr` = 16'hACE1.
  - `cop_mem_stall` = 0, `cop_mem_error` = 0, `cop_mem_rdata` = 0.
  - All `stat_*` = 0.
- Array contents are not reset.
- Reset mid-request: the outstanding request is abandoned. A pending write is not committed. The first cycle after reset is idle.
- `cfg_wait` and `cfg_rand_en` are sampled only at accept; changing them mid-request does not affect the current request.

## Test plan
- Zero-wait write then read: `cfg_wait=0`, `cfg_rand_en=0`.
  - Write addr 32'h10, wdata 32'hDEADBEEF, ben 4'hF → completion one cycle later, error 0.
  - Back-to-back read of 32'h10 → rdata 32'hDEADBEEF, `stat_wr=1`, `stat_rd=1`.
- Byte merge:
  - Write 32'h0 with 32'h11223344, ben 4'hF.
  - Then write 32'h0 with 32'h0000AA00, ben 4'b0010.
  - Read 32'h0 → 32'h1122AA44.
- Fixed waits: `cfg_wait=3`, read accepted in cycle A → stall 1 in A+1..A+3, rdata valid in A+4. `cop_mem_cen` held high during the stall does not create a second access (`stat_rd` increments by 1).
- Out of range with DEPTH_WORDS=1024, BASE_ADDR=0:
  - Write addr 32'h1000 → error 1 in completion cycle, rdata 0, `stat_err=1`.
  - Read 32'h0 → unchanged contents.
- Random waits: `cfg_rand_en=1`, `cfg_wait=0`.
  - 1000 back-to-back reads → each stall run is 0–3 cycles.
  - After reset, the wait sequence is reproducible and matches a reference LFSR seeded 16'hACE1.
  - No read data mismatches.
- Reset mid-write: `cfg_wait=5`, write 32'h4 ← 32'hCAFEF00D over prior 32'h0, reset asserted during the stall.
  - Stall 0 after reset.
  - Read 32'h4 returns 32'h0.
  - All `stat_*` = 0 after reset.

Source files
------------

// File: rtl/scarv_cop_mem_resp.sv
// scarv_cop_mem_resp
// Memory responder at the far end of the COP load/store bus. It serves one
// single-word, byte-enabled read or write at a time from an internal word
// array. It adds fixed and/or pseudo-random wait states and flags
// out-of-range addresses.
//
// Ports
//   g_clk, g_resetn      clock, synchronous active-low reset
//   cop_mem_cen/wen      request valid / write select
//   cop_mem_addr         byte address (bits [1:0] ignored)
//   cop_mem_wdata/ben    write data and byte enables
//   cop_mem_rdata        read data, non-zero only in an in-range read completion
//   cop_mem_stall        request outstanding and not yet complete
//   cop_mem_error        out-of-range access, only in the completion cycle
//   cfg_wait/cfg_rand_en wait-state configuration, sampled at accept
//   stat_rd/wr/err       saturating completion counters
module scarv_cop_mem_resp #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        cop_mem_cen,
   input  logic        cop_mem_wen,
   input  logic [31:0] cop_mem_addr,
   input  logic [31:0] cop_mem_wdata,
   input  logic [3:0]  cop_mem_ben,
   output logic [31:0] cop_mem_rdata,
   output logic        cop_mem_stall,
   output logic        cop_mem_error,
   input  logic [3:0]  cfg_wait,
   input  logic        cfg_rand_en,
   output logic [15:0] stat_rd,
   output logic [15:0] stat_wr,
   output logic [15:0] stat_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem [DEPTH_WORDS];

   logic          pend;
   logic [4:0]    cnt;
   logic          cap_wen;
   logic [AW-1:0] cap_idx;
   logic          cap_oob;
   logic [31:0]   cap_wdata;
   logic [3:0]    cap_ben;
   logic [15:0]   lfsr;

   logic          cmpl;
   logic          accept;
   logic [31:0]   off;
   logic          req_oob;
   logic [4:0]    wait_ld;
   logic [15:0]   lfsr_nxt;
   logic          unused_off;

   assign cmpl   = pend && (cnt == 5'd0);
   // Stalled requests are held by the initiator and must not be re-taken.
   assign accept = cop_mem_cen && (!pend || cmpl);

   // Offset wraps, so addresses below BASE_ADDR land far out of range.
   assign off        = cop_mem_addr - BASE_ADDR;
   assign req_oob    = {2'b00, off[31:2]} >= 32'(DEPTH_WORDS);
   assign unused_off = ^off[1:0];

   // 4-bit fixed plus 2-bit random fits in 5 bits without overflow.
   assign wait_ld = {1'b0, cfg_wait} + (cfg_rand_en ? {3'b000, lfsr[1:0]} : 5'd0);

   // Galois form of x^16+x^14+x^13+x^11+1.
   assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         pend     <= 1'b0;
         cnt      <= 5'd0;
         lfsr     <= 16'hACE1;
         stat_rd  <= 16'd0;
         stat_wr  <= 16'd0;
         stat_err <= 16'd0;
      end else begin
         if (accept) begin
            pend      <= 1'b1;
            cnt       <= wait_ld;
            lfsr      <= lfsr_nxt;
            cap_wen   <= cop_mem_wen;
            cap_idx   <= off[AW+1:2];
            cap_oob   <= req_oob;
            cap_wdata <= cop_mem_wdata;
            cap_ben   <= cop_mem_ben;
         end else if (cmpl) begin
            pend <= 1'b0;
         end else if (pend) begin
            cnt <= cnt - 5'd1;
         end

         if (cmpl) begin
            if (cap_oob) begin
               if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
            end else if (cap_wen) begin
               if (stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
            end else begin
               if (stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
            end
         end
      end
   end

   // Array is not reset; the reset gate keeps a pending write from landing.
   always_ff @(posedge g_clk) begin
      if (g_resetn && cmpl && cap_wen && !cap_oob) begin
         for (int i = 0; i < 4; i++) begin
            if (cap_ben[i]) mem[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
         end
      end
   end

   assign cop_mem_stall = pend && (cnt != 5'd0);
   assign cop_mem_error = cmpl && cap_oob;
   assign cop_mem_rdata = (cmpl && !cap_wen && !cap_oob) ? mem[cap_idx] : 32'd0;

endmodule

// File: tb/tb_scarv_cop_mem_resp.sv
module tb_scarv_cop_mem_resp;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          DEPTH = 1024;

   logic        g_clk = 1'b0;
   logic        g_resetn;
   logic        cop_mem_cen, cop_mem_wen;
   logic [31:0] cop_mem_addr, cop_mem_wdata, cop_mem_rdata;
   logic [3:0]  cop_mem_ben, cfg_wait;
   logic        cop_mem_stall, cop_mem_error, cfg_rand_en;
   logic [15:0] stat_rd, stat_wr, stat_err;

   always #5 g_clk = ~g_clk;

   scarv_cop_mem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen),
      .cop_mem_addr(cop_mem_addr), .cop_mem_wdata(cop_mem_wdata),
      .cop_mem_ben(cop_mem_ben), .cop_mem_rdata(cop_mem_rdata),
      .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error),
      .cfg_wait(cfg_wait), .cfg_rand_en(cfg_rand_en),
      .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_err(stat_err)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: word array, pseudo-random wait source, counters.
   logic [31:0] mdl_mem [DEPTH];
   logic [15:0] mdl_lfsr;
   int          exp_rd, exp_wr, exp_err;
   bit          p_wen;
   logic [31:0] p_addr, p_wdata;
   logic [3:0]  p_ben;
   int          p_k;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic mdl_reset();
      mdl_lfsr = 16'hACE1;
      exp_rd = 0; exp_wr = 0; exp_err = 0;
   endtask

   // Drive a request that will be accepted at the next rising edge.
   task automatic start(input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] ben);
      cop_mem_cen = 1'b1; cop_mem_wen = wen; cop_mem_addr = addr;
      cop_mem_wdata = wdata; cop_mem_ben = ben;
      p_wen = wen; p_addr = addr; p_wdata = wdata; p_ben = ben;
      p_k = int'(cfg_wait) + (cfg_rand_en ? int'(mdl_lfsr[1:0]) : 0);
      mdl_lfsr = lfsr_step(mdl_lfsr);
   endtask

   // Passes the accept edge, counts stall cycles (request held), then checks
   // the completion cycle. Returns positioned in the completion cycle.
   task automatic finish(input string tag);
      int n;
      logic [31:0] off, exp_data;
      bit oob;
      step();
      n = 0;
      while (cop_mem_stall === 1'b1 && n < 40) begin
         n++;
         step();
      end
      check({tag, " waits"}, 32'(n), 32'(p_k));
      off = p_addr - BASE;
      oob = off[31:2] >= 30'(DEPTH);
      exp_data = (!p_wen && !oob) ? mdl_mem[off[11:2]] : 32'd0;
      check({tag, " error"}, {31'd0, cop_mem_error}, {31'd0, oob});
      check({tag, " rdata"}, cop_mem_rdata, exp_data);
      if (oob) exp_err++;
      else if (p_wen) begin
         for (int i = 0; i < 4; i++)
            if (p_ben[i]) mdl_mem[off[11:2]][8*i +: 8] = p_wdata[8*i +: 8];
         exp_wr++;
      end else exp_rd++;
   endtask

   task automatic idle();
      cop_mem_cen = 1'b0;
   endtask

   task automatic xact(input string tag, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] ben);
      start(wen, addr, wdata, ben);
      finish(tag);
      idle();
   endtask

   task automatic check_stats(input string tag);
      check({tag, " stat_rd"},  {16'd0, stat_rd},  32'(exp_rd));
      check({tag, " stat_wr"},  {16'd0, stat_wr},  32'(exp_wr));
      check({tag, " stat_err"}, {16'd0, stat_err}, 32'(exp_err));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   initial begin
      g_resetn = 1'b0; cop_mem_cen = 1'b0; cop_mem_wen = 1'b0;
      cop_mem_addr = '0; cop_mem_wdata = '0; cop_mem_ben = '0;
      cfg_wait = 4'd0; cfg_rand_en = 1'b0;
      mdl_reset();
      step(); step();
      check("reset stall", {31'd0, cop_mem_stall}, 32'd0);
      check("reset error", {31'd0, cop_mem_error}, 32'd0);
      check("reset rdata", cop_mem_rdata, 32'd0);
      check_stats("reset");
      g_resetn = 1'b1;
      step();

      // Zero-wait write, then back-to-back read of the same word.
      start(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      finish("wr10");
      start(1'b0, 32'h10, 32'h0, 4'h0);
      finish("rd10");
      check("rd10 data", cop_mem_rdata, 32'hDEADBEEF);
      idle();
      step();
      check_stats("b2b");

      // Byte merge.
      xact("wr0", 1'b1, 32'h0, 32'h11223344, 4'hF);
      xact("wr0b", 1'b1, 32'h0, 32'h0000AA00, 4'b0010);
      xact("rd0", 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      check("merge model", mdl_mem[0], 32'h1122AA44);

      // Fixed waits, request held through the stall.
      cfg_wait = 4'd3;
      xact("wait3", 1'b0, 32'h10, 32'h0, 4'h0);
      cfg_wait = 4'd0;
      step();
      check_stats("wait3");

      // Out of range write must not alias onto word 0.
      xact("oob", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
      xact("rd0 after oob", 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      check_stats("oob");

      // Fill a small window, then random waits on back-to-back reads.
      for (int i = 0; i < 16; i++) begin
         start(1'b1, 32'(i * 4), $urandom, 4'hF);
         finish("fill");
      end
      cfg_rand_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         start(1'b0, 32'($urandom_range(15) * 4), 32'h0, 4'h0);
         finish("rnd");
      end
      idle();
      cfg_rand_en = 1'b0;
      step();
      check_stats("rnd");

      // Reset in the middle of a stalled write.
      xact("wr4 prior", 1'b1, 32'h4, 32'h0, 4'hF);
      cfg_wait = 4'd5;
      start(1'b1, 32'h4, 32'hCAFEF00D, 4'hF);
      step(); step(); step();
      check("pre-reset stall", {31'd0, cop_mem_stall}, 32'd1);
      idle();
      g_resetn = 1'b0;
      step();
      mdl_reset();
      check("mid reset stall", {31'd0, cop_mem_stall}, 32'd0);
      check_stats("mid reset");
      g_resetn = 1'b1;
      cfg_wait = 4'd0;
      step();
      check("post reset stall", {31'd0, cop_mem_stall}, 32'd0);
      check("post reset rdata", cop_mem_rdata, 32'd0);
      xact("rd4 after reset", 1'b0, 32'h4, 32'h0, 4'h0);

      // Wait sequence after reset tracks a freshly seeded reference.
      cfg_rand_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         start(1'b0, 32'($urandom_range(15) * 4), 32'h0, 4'h0);
         finish("rnd2");
      end
      idle();
      step();
      check_stats("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
